// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - Arbiter state encoding and grant-width helper
package Bus_arb;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    RESP
  } Arb_state;

  function automatic int GRANT_W(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - Bus command and response encodings shared by masters and targets
package Bus;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } Cmd;

  typedef enum logic [1:0] {
    NULL = 2'd0,
    DVA  = 2'd1,
    ERR  = 2'd3
  } Resp;

endpackage

// File: rtl/bus_if.sv
// rtl/bus_if.sv - Single-outstanding command/response bus between one master and one target
interface Bus_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic Clk
);

  Bus::Cmd                 MCmd;
  logic [ADDR_WIDTH-1:0]   MAddr;
  logic [DATA_WIDTH-1:0]   MData;
  logic                    MRespAccept;
  logic                    SCmdAccept;
  Bus::Resp                SResp;
  logic [DATA_WIDTH-1:0]   SData;

  modport master (
    input  Clk,
    output MCmd, MAddr, MData, MRespAccept,
    input  SCmdAccept, SResp, SData
  );

  modport slave (
    input  Clk,
    input  MCmd, MAddr, MData, MRespAccept,
    output SCmdAccept, SResp, SData
  );

endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// rtl/bus_arbiter_rr_pick.sv - Combinational round-robin picker: first requester at or after prio
module rr_pick
  import Bus_arb::*;
#(
  parameter int N = 2,
  parameter int W = GRANT_W(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] prio,
  output logic         valid,
  output logic [W-1:0] idx
);

  function automatic int wrap_idx(input int p, input int k);
    int c;
    c = p + k;
    return (c >= N) ? c - N : c;
  endfunction

  // Scan farthest-first so the candidate nearest to prio is written last and wins.
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[wrap_idx(int'(prio), k)]) begin
        idx = W'(wrap_idx(int'(prio), k));
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - Round-robin arbiter sharing one bus target among several masters
module bus_arbiter
  import Bus_arb::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
) (
  input logic   Clk,
  input logic   MReset_n,
  Bus_if.slave  masters[0:NUM_MASTERS-1],
  Bus_if.master target
);

  localparam int W = GRANT_W(NUM_MASTERS);

  Arb_state               state, state_d;
  logic [W-1:0]           grant, grant_d;
  logic [W-1:0]           prio, prio_d;
  logic [W-1:0]           pick_idx;
  logic                   pick_valid;
  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] racc;
  Bus::Cmd                m_cmd  [NUM_MASTERS];
  logic [ADDR_WIDTH-1:0]  m_addr [NUM_MASTERS];
  logic [DATA_WIDTH-1:0]  m_data [NUM_MASTERS];

  // Interface arrays only allow constant indices, so flatten them here.
  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_port
    logic sel;
    assign sel       = (grant == W'(i));
    assign m_cmd[i]  = masters[i].MCmd;
    assign m_addr[i] = masters[i].MAddr;
    assign m_data[i] = masters[i].MData;
    assign req[i]    = (masters[i].MCmd != Bus::IDLE);
    assign racc[i]   = masters[i].MRespAccept;

    assign masters[i].SCmdAccept = (state == CMD) && sel && target.SCmdAccept;
    assign masters[i].SResp      = ((state == RESP) && sel) ? target.SResp : Bus::NULL;
    assign masters[i].SData      = ((state == RESP) && sel) ? target.SData : '0;
  end

  rr_pick #(.N(NUM_MASTERS), .W(W)) u_pick (
    .req   (req),
    .prio  (prio),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge Clk or negedge MReset_n) begin
    if (!MReset_n) begin
      state <= IDLE;
      grant <= '0;
      prio  <= '0;
    end else begin
      state <= state_d;
      grant <= grant_d;
      prio  <= prio_d;
    end
  end

  always_comb begin
    state_d            = state;
    grant_d            = grant;
    prio_d             = prio;
    target.MCmd        = Bus::IDLE;
    target.MAddr       = '0;
    target.MData       = '0;
    target.MRespAccept = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          state_d = CMD;
        end
      end
      CMD: begin
        target.MCmd  = m_cmd[grant];
        target.MAddr = m_addr[grant];
        target.MData = m_data[grant];
        // A withdrawn command is an abort: prio stays so the same master keeps its turn.
        if (m_cmd[grant] == Bus::IDLE) begin
          state_d = IDLE;
        end else if (target.SCmdAccept) begin
          state_d = RESP;
        end
      end
      RESP: begin
        target.MRespAccept = racc[grant];
        if ((target.SResp != Bus::NULL) && racc[grant]) begin
          prio_d  = (grant == W'(NUM_MASTERS - 1)) ? '0 : grant + W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - Scoreboard bench for bus_arbiter with three masters and a model target
module tb_bus_arbiter;
  import Bus::*;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  Bus_if m_if[0:N-1] (.Clk(clk));
  Bus_if t_if (.Clk(clk));

  bus_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .Clk      (clk),
    .MReset_n (rst_n),
    .masters  (m_if),
    .target   (t_if)
  );

  Cmd          m_cmd  [N];
  logic [31:0] m_addr [N];
  logic [31:0] m_data [N];
  logic [N-1:0] racc;
  logic [N-1:0] keep;
  logic [N-1:0] s_acc;
  Resp         s_resp [N];
  logic [31:0] s_data [N];

  for (genvar i = 0; i < N; i++) begin : g_drv
    assign m_if[i].MCmd        = m_cmd[i];
    assign m_if[i].MAddr       = m_addr[i];
    assign m_if[i].MData       = m_data[i];
    assign m_if[i].MRespAccept = racc[i];
    assign s_acc[i]            = m_if[i].SCmdAccept;
    assign s_resp[i]           = m_if[i].SResp;
    assign s_data[i]           = m_if[i].SData;
  end

  // Model target: accepts when enabled, answers DVA one cycle later until taken.
  logic        tgt_acc_en;
  logic [31:0] tgt_rdata;
  logic        pend;
  logic [31:0] pdata;
  assign t_if.SCmdAccept = tgt_acc_en && (t_if.MCmd != IDLE);
  assign t_if.SResp      = pend ? DVA : NULL;
  assign t_if.SData      = pend ? pdata : 32'h0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend  <= 1'b0;
      pdata <= 32'h0;
    end else begin
      if (pend && t_if.MRespAccept) pend <= 1'b0;
      if (t_if.SCmdAccept) begin
        pend  <= 1'b1;
        pdata <= (t_if.MCmd == RD) ? tgt_rdata : 32'h0;
      end
    end
  end

  typedef struct { int m; Cmd cmd; logic [31:0] addr; logic [31:0] data; int cyc; } acc_t;
  typedef struct { int m; Resp resp; logic [31:0] data; int cyc; } rsp_t;
  acc_t acc_q[$];
  rsp_t rsp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name, input int who);
    checks++;
    errors++;
    $display("FAIL %s: master %0d with nothing expected (cycle %0d)", name, who, cyc);
  endtask

  task automatic issue(input int m, input Cmd c, input logic [31:0] a, input logic [31:0] d);
    m_cmd[m]  = c;
    m_addr[m] = a;
    m_data[m] = d;
  endtask

  task automatic exp_acc(input int m, input Cmd c, input logic [31:0] a, input logic [31:0] d, input int at);
    acc_q.push_back('{m: m, cmd: c, addr: a, data: d, cyc: at});
  endtask

  task automatic exp_rsp(input int m, input logic [31:0] d, input int at);
    rsp_q.push_back('{m: m, resp: DVA, data: d, cyc: at});
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Masters withdraw a command the cycle after it is accepted unless told to keep requesting.
  logic [N-1:0] acc_snap;
  always @(negedge clk) begin
    acc_snap = s_acc;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc_snap[i] && !keep[i]) m_cmd[i] = IDLE;
    end
  end

  always @(negedge clk) begin
    acc_t ea;
    rsp_t er;
    int   nresp;
    if (rst_n === 1'b1) begin
      nresp = 0;
      for (int i = 0; i < N; i++) begin
        if (s_acc[i]) begin
          if (acc_q.size() == 0) begin
            flag("acc_unexpected", i);
          end else begin
            ea = acc_q.pop_front();
            chk("acc_master", i, ea.m);
            chk("acc_cmd", t_if.MCmd, ea.cmd);
            chk("acc_addr", t_if.MAddr, ea.addr);
            chk("acc_data", t_if.MData, ea.data);
            chk("acc_cycle", cyc, ea.cyc);
          end
        end
        if (s_resp[i] != NULL) nresp++;
        if ((s_resp[i] != NULL) && racc[i]) begin
          if (rsp_q.size() == 0) begin
            flag("resp_unexpected", i);
          end else begin
            er = rsp_q.pop_front();
            chk("resp_master", i, er.m);
            chk("resp_code", s_resp[i], er.resp);
            chk("resp_data", s_data[i], er.data);
            chk("resp_cycle", cyc, er.cyc);
          end
        end
      end
      chk("resp_onehot", (nresp <= 1), 1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int k;
    rst_n      = 1'b0;
    tgt_acc_en = 1'b1;
    tgt_rdata  = 32'h0;
    racc       = '1;
    keep       = '0;
    for (int i = 0; i < N; i++) issue(i, IDLE, 32'h0, 32'h0);
    issue(1, RD, 32'h44, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_acc1", s_acc[1], 0);
    chk("rst_resp1", s_resp[1], NULL);
    chk("rst_tcmd", t_if.MCmd, IDLE);
    chk("rst_taddr", t_if.MAddr, 0);
    chk("rst_tracc", t_if.MRespAccept, 0);
    chk("rst_grant", dut.grant, 0);
    chk("rst_prio", dut.prio, 0);
    issue(1, IDLE, 32'h0, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Contention: three writes at once, prio 0 -> order 0,1,2 in 9 cycles.
    k = cyc;
    for (int m = 0; m < N; m++) begin
      issue(m, WR, 32'h100 + 32'(m * 4), 32'hD000_0000 + 32'(m));
      exp_acc(m, WR, 32'h100 + 32'(m * 4), 32'hD000_0000 + 32'(m), k + 1 + 3 * m);
      exp_rsp(m, 32'h0, k + 2 + 3 * m);
    end
    wait_to(k + 10);

    // Single read by master 1.
    k = cyc;
    tgt_rdata = 32'hCAFE_0001;
    issue(1, RD, 32'h10, 32'h0);
    exp_acc(1, RD, 32'h10, 32'h0, k + 1);
    exp_rsp(1, 32'hCAFE_0001, k + 2);
    wait_to(k + 4);

    // Fairness: prio 2, master 0 continuous, master 1 once -> 0, 1, 0.
    k = cyc;
    tgt_rdata = 32'h0000_0A0A;
    keep[0] = 1'b1;
    issue(0, RD, 32'h20, 32'h0);
    issue(1, WR, 32'h24, 32'h1111_2222);
    exp_acc(0, RD, 32'h20, 32'h0, k + 1);
    exp_rsp(0, 32'h0000_0A0A, k + 2);
    exp_acc(1, WR, 32'h24, 32'h1111_2222, k + 4);
    exp_rsp(1, 32'h0, k + 5);
    exp_acc(0, RD, 32'h20, 32'h0, k + 7);
    exp_rsp(0, 32'h0000_0A0A, k + 8);
    wait_to(k + 6);
    keep[0] = 1'b0;
    wait_to(k + 10);

    // Response backpressure: master 1 withholds MRespAccept for 4 RESP cycles.
    k = cyc;
    tgt_rdata = 32'hB0B0_0030;
    racc[1] = 1'b0;
    issue(1, RD, 32'h30, 32'h0);
    exp_acc(1, RD, 32'h30, 32'h0, k + 1);
    exp_rsp(1, 32'hB0B0_0030, k + 6);
    wait_to(k + 2);
    issue(0, WR, 32'h34, 32'h5555);
    exp_acc(0, WR, 32'h34, 32'h5555, k + 8);
    exp_rsp(0, 32'h0, k + 9);
    for (int c = k + 2; c <= k + 5; c++) begin
      wait_to(c);
      @(negedge clk);
      chk("bp_hold_resp", s_resp[1], DVA);
      chk("bp_no_grant0", s_acc[0], 0);
    end
    wait_to(k + 6);
    racc[1] = 1'b1;
    wait_to(k + 11);

    // Abort: prio 1, master 1 withdraws before accept; it wins again over master 2.
    k = cyc;
    tgt_acc_en = 1'b0;
    issue(1, WR, 32'h40, 32'hAB);
    wait_to(k + 3);
    issue(1, IDLE, 32'hDEAD, 32'h0);
    wait_to(k + 4);
    @(negedge clk);
    chk("abort_state", dut.state, Bus_arb::IDLE);
    chk("abort_prio", dut.prio, 1);
    tgt_acc_en = 1'b1;
    tgt_rdata  = 32'h2222_4444;
    issue(1, WR, 32'h48, 32'hAC);
    issue(2, RD, 32'h4C, 32'h0);
    exp_acc(1, WR, 32'h48, 32'hAC, k + 5);
    exp_rsp(1, 32'h0, k + 6);
    exp_acc(2, RD, 32'h4C, 32'h0, k + 8);
    exp_rsp(2, 32'h2222_4444, k + 9);
    wait_to(k + 11);

    // Move prio off zero, then reset while master 1 sits in RESP.
    k = cyc;
    issue(0, WR, 32'h50, 32'h77);
    exp_acc(0, WR, 32'h50, 32'h77, k + 1);
    exp_rsp(0, 32'h0, k + 2);
    wait_to(k + 4);
    k = cyc;
    tgt_rdata = 32'h6060_6060;
    racc[1] = 1'b0;
    issue(1, RD, 32'h60, 32'h0);
    exp_acc(1, RD, 32'h60, 32'h0, k + 1);
    wait_to(k + 2);
    @(negedge clk);
    chk("pre_rst_resp", s_resp[1], DVA);
    chk("pre_rst_prio", dut.prio, 1);
    wait_to(k + 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_resp1", s_resp[1], NULL);
    chk("rst_mid_data1", s_data[1], 0);
    chk("rst_mid_tracc", t_if.MRespAccept, 0);
    racc[1] = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_grant", dut.grant, 0);
    chk("post_rst_prio", dut.prio, 0);
    chk("post_rst_state", dut.state, Bus_arb::IDLE);
    chk("post_rst_resp1", s_resp[1], NULL);
    repeat (3) @(posedge clk);
    #1;

    chk("acc_q_empty", acc_q.size(), 0);
    chk("rsp_q_empty", rsp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter that shares one bus target, typically a register target block, between `NUM_MASTERS` bus masters. It sits between several master-side `Bus_if` ports and a single target-side `Bus_if` port. It allows exactly one outstanding transaction at a time and routes the response back to the master that issued it. Fairness is strict round-robin, with priority rotating past the master that last completed.

## Interface
Parameters:
- `NUM_MASTERS`, default 2: number of requesting masters, range 2..16.
- `ADDR_WIDTH`, default 32: width of `MAddr` on all ports.
- `DATA_WIDTH`, default 32: width of `MData` and `SData` on all ports.

Ports:
- `Clk`  input  1  single clock; identical to `Clk` of every attached interface.
- `MReset_n`  input  1  asynchronous, active-low reset.
- `masters[0:NUM_MASTERS-1]`  `Bus_if.slave`  –  requester ports.
- `target`  `Bus_if.master`  –  port to the shared target.

## Operation
- States: `IDLE`, `CMD`, `RESP`. The registered signal `grant` has width clog2(`NUM_MASTERS`). The round-robin pointer `prio` has the same width.
- In `IDLE`:
  - Requesting masters are those with `MCmd != Bus::IDLE`.
  - Pick the first requester searching `prio`, `prio+1`, … modulo `NUM_MASTERS`.
  - Register the winner into `grant` and go to `CMD`.
  - With no requests, stay in `IDLE`.
- In `CMD`:
  - `target.MCmd`, `MAddr` and `MData` are driven from `masters[grant]`.
  - `masters[grant].SCmdAccept` is driven by `target.SCmdAccept`.
  - On `target.SCmdAccept==1`, go to `RESP`.
  - If the granted master drops `MCmd` to `IDLE` before accept, the command is aborted: return to `IDLE`, leave `prio` unchanged.
- In `RESP`:
  - `target.MCmd` is `Bus::IDLE`.
  - `masters[grant].SResp` and `SData` are driven by `target.SResp` and `SData`.
  - `target.MRespAccept` is driven by `masters[grant].MRespAccept`.
  - When `target.SResp != Bus::NULL` and `MRespAccept` is 1 in the same cycle:
    - set `prio <= grant+1` (wrapping `NUM_MASTERS-1` to 0);
    - go to `IDLE`.
- Every non-granted master, and every master while in `IDLE`, sees `SCmdAccept=0`, `SResp=Bus::NULL`, `SData='0`.
- In `IDLE`, the target sees `MCmd=Bus::IDLE`, `MAddr='0`, `MData='0`, `MRespAccept=0`.
- Reset values: state `IDLE`, `grant=0`, `prio=0`, so all outputs take their `IDLE` values.
- Reset asserted mid-transaction returns to `IDLE` immediately. Any response pending in the target is not forwarded.
- Masters must hold `MCmd`, `MAddr` and `MData` stable until `SCmdAccept`. `MAddr` and `MData` may change while `MCmd` is being dropped (the abort case).

## Timing
- Arbitration costs one cycle: a request first visible at edge t is granted at t+1.
- The command reaches the target combinationally in cycles t+1 onward.
- With an always-accepting target that responds one cycle later, a read issued at t completes as follows:
  - accepted at t+1;
  - `SResp=DVA` to the master at t+2;
  - next arbitration in `IDLE` at t+3.
- Minimum spacing between back-to-back transactions is 3 cycles.
- Simultaneous requests are resolved solely by `prio`. A new request arriving during `CMD` or `RESP` waits for `IDLE`.
- A request held continuously is granted within `NUM_MASTERS` transactions.
- `SData` is valid only in the cycle(s) where `SResp != NULL`.

## Structure
- Package `Bus_arb`: the `Arb_state` enum (`IDLE`, `CMD`, `RESP`) and the `GRANT_W` function (clog2 helper). `Bus::Cmd` and `Bus::Resp` come from the existing `Bus` package.
- Sub-module `rr_pick`:
  - combinational;
  - inputs: request vector and `prio`;
  - outputs: `valid` and winner index.
- The top level holds the FSM and the muxes.

## Test plan
- Single read:
  - master 1 reads address `0x10`; the target returns `0xCAFE0001`.
  - Master 1 sees `SCmdAccept` 1 cycle after request and `SResp=DVA` with `SData=0xCAFE0001`.
  - Master 0 sees `NULL` throughout.
- Contention: masters 0, 1 and 2 (`NUM_MASTERS=3`) all request writes at the same cycle with `prio=0`. Grant order is 0, 1, 2; each completes in 3 cycles; total 9 cycles.
- Fairness: master 0 requests continuously and master 1 requests once. Master 1 is granted immediately after master 0's current transaction; master 0 is not served twice in a row.
- Response backpressure: the granted master holds `MRespAccept=0` for 4 cycles. The arbiter stays in `RESP`, `SResp=DVA` is held, and no other grant is issued. Completion occurs on the cycle `MRespAccept` rises.
- Abort: the granted master drops `MCmd` while the target holds `SCmdAccept=0`. The arbiter returns to `IDLE`, `prio` is unchanged, and the same master wins the next arbitration.
- Reset mid-`RESP`: assert `MReset_n=0` asynchronously. All `SResp`/`SCmdAccept` go to 0/`NULL` immediately, and `grant` and `prio` read 0 after release.
